// File: rtl/opstack_pkg.sv
// opstack_pkg: shared op encoding, default sizes and width helpers for the operand stack
package opstack_pkg;
  typedef enum logic [2:0] {
    NOP       = 3'd0,
    PUSH      = 3'd1,
    POP       = 3'd2,
    POP2_PUSH = 3'd3,
    REPL      = 3'd4,
    SWAP      = 3'd5,
    DUP       = 3'd6,
    RSVD      = 3'd7
  } op_e;
  localparam int OPSTACK_WIDTH = 8;
  localparam int OPSTACK_DEPTH = 16;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int addr_w(input int entries);
    return entries > 1 ? $clog2(entries) : 1;
  endfunction
endpackage

// File: rtl/opstack_spill_ram.sv
// opstack_spill_ram: flop array holding stack entries below top/pen; sync write, async read
module opstack_spill_ram #(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 14,
  parameter int AW      = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [ENTRIES];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/operand_stack.sv
// operand_stack: top/pen held in flops, deeper entries spilled to opstack_spill_ram.
// Define OPSTACK_TRAP_EN to get a sticky err_o on illegal ops; otherwise err_o is tied low.
module operand_stack
  import opstack_pkg::*;
#(
  parameter int WIDTH = OPSTACK_WIDTH,
  parameter int DEPTH = OPSTACK_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  op_e                       op_i,
  input  logic [WIDTH-1:0]          din_i,
  output logic [WIDTH-1:0]          top_o,
  output logic [WIDTH-1:0]          pen_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      err_o
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = addr_w(DEPTH - 2);
  logic [WIDTH-1:0] top_n, pen_n, rdata, spill;
  logic [CW-1:0]    cnt_n;
  logic [AW-1:0]    waddr, raddr;
  logic             ok, we, two, three;
  assign empty_o = count_o == '0;
  assign full_o  = count_o == CW'(DEPTH);
  assign two     = count_o >= CW'(2);
  assign three   = count_o >= CW'(3);
  // sp = count-2 is the fill level; reads come from sp-1, guarded so the address stays in range
  assign waddr   = AW'(count_o - CW'(2));
  assign raddr   = three ? AW'(count_o - CW'(3)) : '0;
  assign spill   = three ? rdata : '0;
  opstack_spill_ram #(.WIDTH(WIDTH), .ENTRIES(DEPTH - 2), .AW(AW)) u_ram (
    .clk  (clk),
    .we   (we && ok),
    .waddr(waddr),
    .wdata(pen_o),
    .raddr(raddr),
    .rdata(rdata)
  );
  always_comb begin
    ok    = 1'b1;
    we    = 1'b0;
    top_n = top_o;
    pen_n = pen_o;
    cnt_n = count_o;
    case (op_i)
      PUSH:      begin ok = !full_o; top_n = din_i; pen_n = top_o; cnt_n = count_o + CW'(1); we = two; end
      POP:       begin ok = !empty_o; top_n = pen_o; pen_n = spill; cnt_n = count_o - CW'(1); end
      POP2_PUSH: begin ok = two; top_n = din_i; pen_n = spill; cnt_n = count_o - CW'(1); end
      REPL:      begin ok = !empty_o; top_n = din_i; end
      SWAP:      begin ok = two; top_n = pen_o; pen_n = top_o; end
      DUP:       begin ok = !empty_o && !full_o; pen_n = top_o; cnt_n = count_o + CW'(1); we = two; end
      default:   ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      top_o   <= '0;
      pen_o   <= '0;
      count_o <= '0;
    end else if (ok) begin
      top_o   <= top_n;
      pen_o   <= pen_n;
      count_o <= cnt_n;
    end
`ifdef OPSTACK_TRAP_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_o <= 1'b0;
    else if (!ok) err_o <= 1'b1;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_operand_stack.sv
// tb_operand_stack: directed checks of operand_stack (DEPTH=16, WIDTH=8); trap checks follow OPSTACK_TRAP_EN
module tb_operand_stack;
  import opstack_pkg::*;
`ifdef OPSTACK_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  op_e        op = NOP;
  logic [7:0] din = '0;
  logic [7:0] top, pen;
  logic [4:0] count;
  logic       empty, full, err;
  int checks = 0;
  int errors = 0;

  operand_stack #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .op_i(op), .din_i(din),
    .top_o(top), .pen_o(pen), .count_o(count),
    .empty_o(empty), .full_o(full), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic step(input op_e o, input logic [7:0] d);
    op = o;
    din = d;
    @(posedge clk);
    #1;
    op = NOP;
  endtask

  task automatic do_reset;
    op = NOP;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({top, pen, count, empty, full, err} !== {8'h00, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got top=%h pen=%h cnt=%0d e=%b f=%b err=%b, exp 00 00 0 1 0 0", top, pen, count, empty, full, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_push_pop;
    do_reset();
    step(PUSH, 8'h11);
    step(PUSH, 8'h22);
    step(PUSH, 8'h33);
    checks++;
    if ({top, pen, count} !== {8'h33, 8'h22, 5'd3}) begin
      errors++;
      $display("FAIL push3: got %h %h %0d, exp 33 22 3", top, pen, count);
    end
    step(POP, 8'h00);
    checks++;
    if ({top, pen, count} !== {8'h22, 8'h11, 5'd2}) begin
      errors++;
      $display("FAIL pop1: got %h %h %0d, exp 22 11 2", top, pen, count);
    end
  endtask

  task automatic test_full;
    logic ok;
    do_reset();
    for (int i = 1; i <= 16; i++) step(PUSH, 8'(i));
    checks++;
    if ({top, pen, count, full, empty} !== {8'd16, 8'd15, 5'd16, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fill16: got %h %h %0d f=%b e=%b, exp 10 0f 16 1 0", top, pen, count, full, empty);
    end
    step(PUSH, 8'h99);
    checks++;
    if ({top, pen, count, full} !== {8'd16, 8'd15, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL overflow_push: got %h %h %0d f=%b, exp 10 0f 16 1", top, pen, count, full);
    end
    checks++;
    if (err !== TRAP) begin
      errors++;
      $display("FAIL overflow_err: got %b exp %b", err, TRAP);
    end
    step(DUP, 8'h00);
    checks++;
    if ({top, pen, count} !== {8'd16, 8'd15, 5'd16}) begin
      errors++;
      $display("FAIL overflow_dup: got %h %h %0d, exp 10 0f 16", top, pen, count);
    end
    ok = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step(POP, 8'h00);
      if (top !== 8'(16 - k) || pen !== 8'(15 - k) || count !== 5'(16 - k)) begin
        ok = 1'b0;
        $display("FAIL drain_%0d: got %h %h %0d, exp %h %h %0d", k, top, pen, count, 8'(16 - k), 8'(15 - k), 16 - k);
      end
    end
    checks++;
    if (!ok) errors++;
  endtask

  task automatic test_alu;
    do_reset();
    step(PUSH, 8'h05);
    step(PUSH, 8'h03);
    step(POP2_PUSH, 8'h08);
    checks++;
    if ({top, pen, count} !== {8'h08, 8'h00, 5'd1}) begin
      errors++;
      $display("FAIL pop2push: got %h %h %0d, exp 08 00 1", top, pen, count);
    end
    step(REPL, 8'hF7);
    checks++;
    if ({top, pen, count} !== {8'hF7, 8'h00, 5'd1}) begin
      errors++;
      $display("FAIL repl: got %h %h %0d, exp f7 00 1", top, pen, count);
    end
    step(SWAP, 8'h00);
    step(POP2_PUSH, 8'h44);
    step(RSVD, 8'h55);
    checks++;
    if ({top, pen, count} !== {8'hF7, 8'h00, 5'd1}) begin
      errors++;
      $display("FAIL illegal_at1: got %h %h %0d, exp f7 00 1", top, pen, count);
    end
  endtask

  task automatic test_underflow;
    do_reset();
    step(POP, 8'h00);
    step(REPL, 8'h12);
    checks++;
    if ({top, pen, count, empty} !== {8'h00, 8'h00, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL underflow: got %h %h %0d e=%b, exp 00 00 0 1", top, pen, count, empty);
    end
    step(NOP, 8'h00);
    step(PUSH, 8'h01);
    checks++;
    if (err !== TRAP) begin
      errors++;
      $display("FAIL underflow_err_sticky: got %b exp %b", err, TRAP);
    end
    do_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b exp 0", err);
    end
  endtask

  task automatic test_swap_dup;
    do_reset();
    step(PUSH, 8'h0A);
    step(PUSH, 8'h0B);
    step(SWAP, 8'h00);
    checks++;
    if ({top, pen, count} !== {8'h0A, 8'h0B, 5'd2}) begin
      errors++;
      $display("FAIL swap: got %h %h %0d, exp 0a 0b 2", top, pen, count);
    end
    step(DUP, 8'h00);
    checks++;
    if ({top, pen, count} !== {8'h0A, 8'h0A, 5'd3}) begin
      errors++;
      $display("FAIL dup: got %h %h %0d, exp 0a 0a 3", top, pen, count);
    end
    step(POP, 8'h00);
    checks++;
    if ({top, pen, count} !== {8'h0A, 8'h0B, 5'd2}) begin
      errors++;
      $display("FAIL dup_pop1: got %h %h %0d, exp 0a 0b 2", top, pen, count);
    end
    step(POP, 8'h00);
    step(POP, 8'h00);
    checks++;
    if ({top, pen, count, empty} !== {8'h00, 8'h00, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL dup_pop3: got %h %h %0d e=%b, exp 00 00 0 1", top, pen, count, empty);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int i = 1; i <= 10; i++) step(PUSH, 8'(i + 8'h20));
    checks++;
    if ({top, pen, count} !== {8'h2A, 8'h29, 5'd10}) begin
      errors++;
      $display("FAIL fill10: got %h %h %0d, exp 2a 29 10", top, pen, count);
    end
    op = PUSH;
    din = 8'h55;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({top, pen, count, empty, full, err} !== {8'h00, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %h %h %0d e=%b f=%b err=%b, exp 00 00 0 1 0 0", top, pen, count, empty, full, err);
    end
    op = NOP;
    @(negedge clk);
    rst_n = 1'b1;
    step(PUSH, 8'h42);
    checks++;
    if ({top, pen, count} !== {8'h42, 8'h00, 5'd1}) begin
      errors++;
      $display("FAIL post_reset_push: got %h %h %0d, exp 42 00 1", top, pen, count);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full();
    test_alu();
    test_underflow();
    test_swap_dup();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
